grid_io_param: RTL and testbench
================================

GRID_IO_PARAM -- requirements
Module: grid_io_param

Interface
REQ-001 SHALL have parameter NUM_IO, default 4: number of I/O subtiles, legal range 1..32.
REQ-002 SHALL have parameter CFG_W, fixed at 3: configuration bits per subtile; not overridable.
REQ-003 SHALL have one clock and a synchronous, active-high reset: prog_clk is the clock and prog_reset is the reset.
REQ-004 SHALL have port prog_clk, input, 1 bit: the only clock; all flops sample on its rising edge.
REQ-005 SHALL have port prog_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ccff_head, input, 1 bit: configuration chain serial input.
REQ-007 SHALL have port ccff_shift_en, input, 1 bit: the chain advances one bit per cycle while this is high.
REQ-008 SHALL have port cfg_commit, input, 1 bit: one-cycle pulse that copies the chain into the active configuration.
REQ-009 SHALL have port isol_n, input, 1 bit: active-low isolation.
REQ-010 SHALL have port gfpga_pad_io_soc_in, input, NUM_IO bits: pad input values.
REQ-011 SHALL have port io_outpad, input, NUM_IO bits: fabric-side output data.
REQ-012 SHALL have port ccff_tail, output, 1 bit: configuration chain serial output.
REQ-013 SHALL have port gfpga_pad_io_soc_dir, output, NUM_IO bits: pad direction, 1 = drive pad, 0 = input.
REQ-014 SHALL have port gfpga_pad_io_soc_out, output, NUM_IO bits: pad output data.
REQ-015 SHALL have port io_inpad, output, NUM_IO bits: fabric-side input data.
REQ-016 SHALL have port cfg_loaded, output, 1 bit: asserted once a full chain's worth of bits has been shifted since the last commit or reset.

Function
REQ-017 SHALL hold a shift chain chain[0..NUM_IO*CFG_W-1]; when ccff_shift_en=1: chain[0]<=ccff_head, chain[i]<=chain[i-1]; when ccff_shift_en=0 the chain holds.
REQ-018 SHALL drive ccff_tail = chain[NUM_IO*CFG_W-1] directly from a flop, with no combinational path from ccff_head.
REQ-019 SHALL assign subtile k the slice chain[3k+2:3k]: bit 3k = oe, bit 3k+1 = in_sync, bit 3k+2 = out_inv.
REQ-020 SHALL, on a cycle with cfg_commit=1, load the active configuration register from the chain value present before that edge; outputs use only the active configuration, never the chain, so shifting cannot glitch pads.
REQ-021 SHALL drive soc_dir[k] = active oe[k] AND isol_n.
REQ-022 SHALL drive soc_out[k] = (io_outpad[k] XOR active out_inv[k]) when isol_n=1 and active oe[k]=1, else 0; this path is combinational.
REQ-023 SHALL, for each subtile, run a two-flop synchronizer s1<=soc_in[k], s2<=s1 every cycle, independent of configuration.
REQ-024 SHALL drive io_inpad[k] = s2[k] if active in_sync[k]=1, else soc_in[k] combinationally, forced to 0 when isol_n=0; the input path is independent of oe (loopback allowed).
REQ-025 SHALL keep bit counter cnt, width $clog2(NUM_IO*CFG_W+1), incrementing on each shift cycle and saturating at NUM_IO*CFG_W.
REQ-026 SHALL drive cfg_loaded = (cnt == NUM_IO*CFG_W), registered through the counter.
REQ-027 SHALL, when cfg_commit=1 and ccff_shift_en=1 in the same cycle: commit captures the pre-shift chain, the chain still shifts, and cnt goes to 0 (clear wins).
REQ-028 SHALL accept a commit before cfg_loaded=1 and apply it without error, committing the partial chain as-is.
REQ-029 SHALL let the isolation override (isol_n=0) act combinationally, leaving all state (chain, active config, cnt, synchronizers) unaffected.

Reset
REQ-030 SHALL, while prog_reset=1 at a rising edge, clear chain, active config, cnt and both synchronizer stages to 0; reset overrides shift and commit.
REQ-031 SHALL, once out of reset, present ccff_tail=0, cfg_loaded=0, soc_dir=0, soc_out=0; io_inpad follows soc_in combinationally (in_sync=0).
REQ-032 SHALL, on a reset applied mid-shift, discard the partial chain and require the next load to start with cnt=0.

Verification
REQ-033 SHALL cover: NUM_IO=4, reset, shift 12 bits such that IO2 gets oe=1,out_inv=1, commit, io_outpad[2]=0 -> soc_dir=4'b0100, soc_out[2]=1, cfg_loaded=1 before commit and 0 after.
REQ-034 SHALL cover: IO0 in_sync=1, soc_in[0] rises at edge N -> io_inpad[0] rises after edge N+2; IO1 in_sync=0 -> io_inpad[1] follows soc_in[1] in the same cycle.
REQ-035 SHALL cover: after a commit, shift 5 new bits without commit -> soc_dir/soc_out unchanged, cnt=5, cfg_loaded=0.
REQ-036 SHALL cover: isol_n=0 with oe=1 on all IOs -> soc_dir=0, soc_out=0, io_inpad=0; isol_n=1 -> the previous values return with no reload.
REQ-037 SHALL cover: commit and shift in the same cycle -> the active config equals the pre-shift chain, cnt=0, and ccff_tail advances by one bit.
REQ-038 SHALL cover: a 25-bit bitstream with NUM_IO=8 -> ccff_tail emits the first bit 24 shift cycles after it entered, and cfg_loaded=1 exactly after shift 24.

Source files
------------

// File: rtl/grid_io_param.sv
// Parameterised I/O tile: serial configuration chain with a shadowed active
// configuration, per-pad direction/inversion control and optional input synchronizer.
module grid_io_param #(
    parameter int NUM_IO = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_shift_en,
    input  logic              cfg_commit,
    input  logic              isol_n,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic              ccff_tail,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] io_inpad,
    output logic              cfg_loaded
);

    localparam int CFG_W   = 3;
    localparam int CHAIN_W = NUM_IO * CFG_W;
    localparam int CNT_W   = $clog2(CHAIN_W + 1);

    logic [CHAIN_W-1:0] r_chain;
    logic [CHAIN_W-1:0] r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_IO-1:0]  r_sync1;
    logic [NUM_IO-1:0]  r_sync2;

    logic               w_full;
    logic [NUM_IO-1:0]  w_oe;
    logic [NUM_IO-1:0]  w_in_sync;
    logic [NUM_IO-1:0]  w_out_inv;
    logic [NUM_IO-1:0]  w_isol_mask;

    assign w_full = (r_cnt == CNT_W'(CHAIN_W));

    // Commit samples the pre-edge chain, so a shift in the same cycle does not leak in.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_chain  <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
        end else begin
            r_sync1 <= gfpga_pad_io_soc_in;
            r_sync2 <= r_sync1;
            if (ccff_shift_en) begin
                r_chain <= {r_chain[CHAIN_W-2:0], ccff_head};
            end
            if (cfg_commit) begin
                r_active <= r_chain;
            end
            if (cfg_commit) begin
                r_cnt <= '0;
            end else if (ccff_shift_en && !w_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_oe      = '0;
        w_in_sync = '0;
        w_out_inv = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            w_oe[k]      = r_active[CFG_W*k];
            w_in_sync[k] = r_active[CFG_W*k+1];
            w_out_inv[k] = r_active[CFG_W*k+2];
        end
    end

    // Isolation is purely a combinational mask; no state is touched by it.
    assign w_isol_mask          = {NUM_IO{isol_n}};
    assign ccff_tail            = r_chain[CHAIN_W-1];
    assign cfg_loaded           = w_full;
    assign gfpga_pad_io_soc_dir = w_oe & w_isol_mask;
    assign gfpga_pad_io_soc_out = (io_outpad ^ w_out_inv) & w_oe & w_isol_mask;
    assign io_inpad             = ((w_in_sync & r_sync2) | (~w_in_sync & gfpga_pad_io_soc_in))
                                  & w_isol_mask;

endmodule

// File: tb/tb_grid_io_param.sv
// Directed testbench for grid_io_param: table of configuration vectors plus
// hand-written sequences for synchronizer latency, partial loads, commit/shift overlap and reset.
module tb_grid_io_param;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       ccff_head, ccff_shift_en, cfg_commit, isol_n;
    logic [3:0] soc_in, outpad;
    logic       tail, loaded;
    logic [3:0] soc_dir, soc_out, inpad;

    logic       head8, shift8, commit8, isol8;
    logic [7:0] soc_in8, outpad8;
    logic       tail8, loaded8;
    logic [7:0] soc_dir8, soc_out8, inpad8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] cfg;
        logic        isol;
        logic [3:0]  op;
        logic [3:0]  si;
        logic [3:0]  expDir;
        logic [3:0]  expOut;
        logic [3:0]  expIn;
    } vec_t;

    vec_t vecs[6];

    always #5 prog_clk = ~prog_clk;

    grid_io_param #(.NUM_IO(4)) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .ccff_head            (ccff_head),
        .ccff_shift_en        (ccff_shift_en),
        .cfg_commit           (cfg_commit),
        .isol_n               (isol_n),
        .gfpga_pad_io_soc_in  (soc_in),
        .io_outpad            (outpad),
        .ccff_tail            (tail),
        .gfpga_pad_io_soc_dir (soc_dir),
        .gfpga_pad_io_soc_out (soc_out),
        .io_inpad             (inpad),
        .cfg_loaded           (loaded)
    );

    grid_io_param #(.NUM_IO(8)) dut8 (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .ccff_head            (head8),
        .ccff_shift_en        (shift8),
        .cfg_commit           (commit8),
        .isol_n               (isol8),
        .gfpga_pad_io_soc_in  (soc_in8),
        .io_outpad            (outpad8),
        .ccff_tail            (tail8),
        .gfpga_pad_io_soc_dir (soc_dir8),
        .gfpga_pad_io_soc_out (soc_out8),
        .io_inpad             (inpad8),
        .cfg_loaded           (loaded8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shiftBit(input logic b);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        tick();
        ccff_shift_en = 1'b0;
    endtask

    // MSB goes in first so that it ends up in chain[11].
    task automatic shiftWord(input logic [11:0] w);
        for (int i = 11; i >= 0; i--) shiftBit(w[i]);
    endtask

    task automatic commitCfg();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic applyStimulus(input logic isol, input logic [3:0] op, input logic [3:0] si);
        isol_n = isol;
        outpad = op;
        soc_in = si;
        #1;
    endtask

    task automatic doReset();
        prog_reset = 1'b1;
        tick();
        tick();
        prog_reset = 1'b0;
    endtask

    initial begin
        prog_reset = 1'b1; ccff_head = 1'b0; ccff_shift_en = 1'b0; cfg_commit = 1'b0;
        isol_n = 1'b1; soc_in = 4'b0000; outpad = 4'b0000;
        head8 = 1'b0; shift8 = 1'b0; commit8 = 1'b0; isol8 = 1'b1;
        soc_in8 = 8'h00; outpad8 = 8'h00;

        //        cfg      isol  outpad   soc_in   dir      out      inpad
        vecs[0] = '{12'h140, 1'b1, 4'b0000, 4'b1010, 4'b0100, 4'b0100, 4'b1010};
        vecs[1] = '{12'h249, 1'b1, 4'b1011, 4'b0110, 4'b1111, 4'b1011, 4'b0110};
        vecs[2] = '{12'hB6D, 1'b1, 4'b1011, 4'b1001, 4'b1111, 4'b0100, 4'b1001};
        vecs[3] = '{12'hB6D, 1'b0, 4'b1011, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        vecs[4] = '{12'h024, 1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b0101};
        vecs[5] = '{12'h228, 1'b1, 4'b0000, 4'b1111, 4'b1010, 4'b0010, 4'b1111};

        // Reset state
        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b0110);
        checkOutput("rst_tail", 32'(tail), 32'd0);
        checkOutput("rst_loaded", 32'(loaded), 32'd0);
        checkOutput("rst_dir", 32'(soc_dir), 32'd0);
        checkOutput("rst_out", 32'(soc_out), 32'd0);
        checkOutput("rst_inpad", 32'(inpad), 32'h6);

        // Table of full loads followed by a commit
        for (int i = 0; i < 6; i++) begin
            shiftWord(vecs[i].cfg);
            checkOutput($sformatf("vec%0d_loaded_pre", i), 32'(loaded), 32'd1);
            commitCfg();
            checkOutput($sformatf("vec%0d_loaded_post", i), 32'(loaded), 32'd0);
            applyStimulus(vecs[i].isol, vecs[i].op, vecs[i].si);
            checkOutput($sformatf("vec%0d_dir", i), 32'(soc_dir), 32'(vecs[i].expDir));
            checkOutput($sformatf("vec%0d_out", i), 32'(soc_out), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d_inpad", i), 32'(inpad), 32'(vecs[i].expIn));
        end

        // Synchronizer latency on IO0, direct path on IO1
        shiftWord(12'h002);
        commitCfg();
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        tick(); tick(); tick();
        applyStimulus(1'b1, 4'b0000, 4'b0011);
        checkOutput("sync_io1_direct", 32'(inpad[1]), 32'd1);
        checkOutput("sync_io0_edgeN", 32'(inpad[0]), 32'd0);
        tick();
        checkOutput("sync_io0_edgeN1", 32'(inpad[0]), 32'd0);
        tick();
        checkOutput("sync_io0_edgeN2", 32'(inpad[0]), 32'd1);

        // Partial shift after a commit leaves pads alone; count resumes from 5
        shiftWord(12'h140);
        commitCfg();
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) shiftBit(1'b1);
        checkOutput("partial_dir", 32'(soc_dir), 32'h4);
        checkOutput("partial_out", 32'(soc_out), 32'h4);
        checkOutput("partial_loaded", 32'(loaded), 32'd0);
        for (int i = 0; i < 6; i++) shiftBit(1'b0);
        checkOutput("partial_loaded_11", 32'(loaded), 32'd0);
        shiftBit(1'b0);
        checkOutput("partial_loaded_12", 32'(loaded), 32'd1);

        // Isolation toggles without a reload
        shiftWord(12'hB6D);
        commitCfg();
        applyStimulus(1'b0, 4'b0011, 4'b1100);
        checkOutput("isol_dir", 32'(soc_dir), 32'h0);
        checkOutput("isol_out", 32'(soc_out), 32'h0);
        checkOutput("isol_inpad", 32'(inpad), 32'h0);
        tick();
        applyStimulus(1'b1, 4'b0011, 4'b1100);
        checkOutput("unisol_dir", 32'(soc_dir), 32'hF);
        checkOutput("unisol_out", 32'(soc_out), 32'hC);
        checkOutput("unisol_inpad", 32'(inpad), 32'hC);

        // Commit and shift in the same cycle
        shiftWord(12'h140);
        commitCfg();
        shiftWord(12'hB6D);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("overlap_tail_pre", 32'(tail), 32'd1);
        checkOutput("overlap_dir_pre", 32'(soc_dir), 32'h4);
        ccff_head = 1'b1; ccff_shift_en = 1'b1; cfg_commit = 1'b1;
        tick();
        ccff_shift_en = 1'b0; cfg_commit = 1'b0;
        checkOutput("overlap_dir", 32'(soc_dir), 32'hF);
        checkOutput("overlap_out", 32'(soc_out), 32'hF);
        checkOutput("overlap_loaded", 32'(loaded), 32'd0);
        checkOutput("overlap_tail_post", 32'(tail), 32'd0);
        for (int i = 0; i < 11; i++) shiftBit(1'b0);
        checkOutput("overlap_loaded_11", 32'(loaded), 32'd0);
        shiftBit(1'b0);
        checkOutput("overlap_loaded_12", 32'(loaded), 32'd1);

        // Reset in the middle of a load
        for (int i = 0; i < 6; i++) shiftBit(1'b1);
        doReset();
        checkOutput("midrst_tail", 32'(tail), 32'd0);
        checkOutput("midrst_dir", 32'(soc_dir), 32'h0);
        checkOutput("midrst_loaded", 32'(loaded), 32'd0);
        for (int i = 0; i < 11; i++) shiftBit(1'b1);
        checkOutput("midrst_loaded_11", 32'(loaded), 32'd0);
        checkOutput("midrst_tail_11", 32'(tail), 32'd0);
        shiftBit(1'b1);
        checkOutput("midrst_loaded_12", 32'(loaded), 32'd1);
        checkOutput("midrst_tail_12", 32'(tail), 32'd1);

        // 25-bit stream into the 8-IO instance: a single 1 followed by zeros
        for (int i = 1; i <= 25; i++) begin
            head8  = (i == 1);
            shift8 = 1'b1;
            tick();
            shift8 = 1'b0;
            if (i >= 23) begin
                checkOutput($sformatf("io8_tail_%0d", i), 32'(tail8), 32'(i == 24));
                checkOutput($sformatf("io8_loaded_%0d", i), 32'(loaded8), 32'(i >= 24));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
